// File: rtl/router_pkg.sv
// Width constants, header layout and FSM states shared by the Aurora
// encapsulation and decapsulation blocks.
package router_pkg;

  localparam int DATA_WIDTH             = 1024;
  localparam int ADDR_WIDTH             = 10;
  localparam int DATA_DFX_WIDTH         = DATA_WIDTH + ADDR_WIDTH;
  localparam int RECOGNIZE_ROUTER_WIDTH = 2;
  localparam int NUMBER_PACKET          = 19;
  localparam int IDX_WIDTH              = $clog2(NUMBER_PACKET);
  localparam int TTL_WIDTH              = $clog2(3);
  localparam int HEADER_WIDTH           = RECOGNIZE_ROUTER_WIDTH + IDX_WIDTH + TTL_WIDTH;
  localparam int AURORA_DATA_WIDTH      = 64;
  localparam int PAYLOAD_WIDTH          = AURORA_DATA_WIDTH - HEADER_WIDTH;

  localparam int HDR_TTL_LSB = 0;
  localparam int HDR_IDX_LSB = HDR_TTL_LSB + TTL_WIDTH;
  localparam int HDR_RID_LSB = HDR_IDX_LSB + IDX_WIDTH;
  localparam int LAST_IDX    = NUMBER_PACKET - 1;

  // Bits of the DFX word carried by the final Aurora word; the rest is padding.
  localparam int LAST_USED_BITS = DATA_DFX_WIDTH - LAST_IDX * PAYLOAD_WIDTH;

  typedef struct packed {
    logic [RECOGNIZE_ROUTER_WIDTH-1:0] rid;
    logic [IDX_WIDTH-1:0]              idx;
    logic [TTL_WIDTH-1:0]              ttl;
  } hdr_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } decap_state_t;

endpackage

// File: rtl/decap_hdr_check.sv
// Classifies one received Aurora word against the frame being collected:
// start of frame, in-sequence accept, or error (with resync on index 0).
module decap_hdr_check
  import router_pkg::*;
(
  input  logic                              valid_i,
  input  logic                              collect_i,
  input  hdr_t                              hdr_i,
  input  logic [IDX_WIDTH-1:0]              cnt_i,
  input  logic [RECOGNIZE_ROUTER_WIDTH-1:0] ref_rid_i,
  input  logic [TTL_WIDTH-1:0]              ref_ttl_i,
  output logic                              start_o,
  output logic                              accept_o,
  output logic                              last_o,
  output logic                              err_o
);

  logic idx_zero;
  logic seq_ok;
  logic ref_ok;

  assign idx_zero = (hdr_i.idx == '0);
  assign seq_ok   = (hdr_i.idx == cnt_i) && (hdr_i.idx <= IDX_WIDTH'(LAST_IDX));
  assign ref_ok   = (hdr_i.rid == ref_rid_i) && (hdr_i.ttl == ref_ttl_i);

  always_comb begin
    start_o  = 1'b0;
    accept_o = 1'b0;
    err_o    = 1'b0;
    if (valid_i) begin
      if (!collect_i) begin
        start_o = idx_zero;
        err_o   = !idx_zero;
      end else if (seq_ok && ref_ok) begin
        accept_o = 1'b1;
      end else begin
        // A bad word that is itself index 0 restarts collection.
        err_o   = 1'b1;
        start_o = idx_zero;
      end
    end
  end

  assign last_o = accept_o && (hdr_i.idx == IDX_WIDTH'(LAST_IDX));

endmodule

// File: rtl/decap_packet.sv
// Reassembles a 1034-bit DFX word from 19 consecutive Aurora words, checking
// header sequence and router/TTL consistency; malformed frames are dropped.
module decap_packet
  import router_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
  input  logic                         data_recv_valid,
  output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
  output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
  output logic                         decap_done,
  output logic                         decap_err,
  output logic                         decap_busy
);

  hdr_t                   hdr;
  logic [PAYLOAD_WIDTH-1:0] payload;

  assign hdr     = hdr_t'(data_recv[HEADER_WIDTH-1:0]);
  assign payload = data_recv[AURORA_DATA_WIDTH-1:HEADER_WIDTH];

  decap_state_t                      state_q, state_d;
  logic [IDX_WIDTH-1:0]              cnt_q, cnt_d;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] ref_rid_q, ref_rid_d;
  logic [TTL_WIDTH-1:0]              ref_ttl_q, ref_ttl_d;
  logic [DATA_DFX_WIDTH-1:0]         data_q, data_d;
  logic [HEADER_WIDTH-1:0]           hdr_q, hdr_d;
  logic                              done_q, done_d;
  logic                              err_q, err_d;

  logic                 start, accept, last, err;
  logic                 wr_en;
  logic [IDX_WIDTH-1:0] wr_slot;

  decap_hdr_check u_hdr_check (
    .valid_i   (data_recv_valid),
    .collect_i (state_q == ST_COLLECT),
    .hdr_i     (hdr),
    .cnt_i     (cnt_q),
    .ref_rid_i (ref_rid_q),
    .ref_ttl_i (ref_ttl_q),
    .start_o   (start),
    .accept_o  (accept),
    .last_o    (last),
    .err_o     (err)
  );

  // The last word is merged straight into the output, so only 18 slots are stored.
  logic [PAYLOAD_WIDTH-1:0]          shadow_q [LAST_IDX];
  logic [LAST_IDX*PAYLOAD_WIDTH-1:0] shadow_flat;

  for (genvar gi = 0; gi < LAST_IDX; gi++) begin : g_slot
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q[gi] <= '0;
      end else if (wr_en && (wr_slot == IDX_WIDTH'(gi))) begin
        shadow_q[gi] <= payload;
      end
    end
    assign shadow_flat[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = shadow_q[gi];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_rid_d = ref_rid_q;
    ref_ttl_d = ref_ttl_q;
    data_d    = data_q;
    hdr_d     = hdr_q;
    done_d    = 1'b0;
    err_d     = err;
    wr_en     = 1'b0;
    wr_slot   = cnt_q;
    if (start) begin
      wr_en     = 1'b1;
      wr_slot   = '0;
      cnt_d     = IDX_WIDTH'(1);
      ref_rid_d = hdr.rid;
      ref_ttl_d = hdr.ttl;
      state_d   = ST_COLLECT;
    end else if (err) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (last) begin
      data_d  = {payload[LAST_USED_BITS-1:0], shadow_flat};
      hdr_d   = {ref_rid_q, {IDX_WIDTH{1'b0}}, ref_ttl_q};
      done_d  = 1'b1;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (accept) begin
      wr_en = 1'b1;
      cnt_d = cnt_q + IDX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ref_rid_q <= '0;
      ref_ttl_q <= '0;
      data_q    <= '0;
      hdr_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_rid_q <= ref_rid_d;
      ref_ttl_q <= ref_ttl_d;
      data_q    <= data_d;
      hdr_q     <= hdr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign data_dfx_recv   = data_q;
  assign header_pkt_recv = hdr_q;
  assign decap_done      = done_q;
  assign decap_err       = err_q;
  assign decap_busy      = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_decap_packet.sv
// Scoreboard bench for decap_packet: a frame-level model predicts done/err
// strobes and the rebuilt word; a negedge monitor checks them as they appear.
module tb_decap_packet;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   data_recv = '0;
  logic          data_recv_valid = 1'b0;
  logic [1033:0] data_dfx_recv;
  logic [8:0]    header_pkt_recv;
  logic          decap_done, decap_err, decap_busy;

  decap_packet dut (
    .clk             (clk),
    .rst             (rst),
    .data_recv       (data_recv),
    .data_recv_valid (data_recv_valid),
    .data_dfx_recv   (data_dfx_recv),
    .header_pkt_recv (header_pkt_recv),
    .decap_done      (decap_done),
    .decap_err       (decap_err),
    .decap_busy      (decap_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int            cyc;
    bit            is_done;
    logic [1033:0] data;
    logic [8:0]    hdr;
  } ev_t;
  ev_t exp_q[$];

  // Frame-level reference: -1 when idle, else index of the next expected word.
  int            m_next = -1;
  logic [1:0]    m_rid, m_ttl;
  logic [54:0]   m_words [19];
  logic [1033:0] m_last = '0;

  task automatic chk(input string nm, input logic [1033:0] act, input logic [1033:0] expv);
    int d;
    compared++;
    if (act !== expv) begin
      d = -1;
      for (int i = 0; i < 1034; i++) if (act[i] !== expv[i] && d < 0) d = i;
      mismatched++;
      $display("FAIL %s @cyc %0d: got %h, expected %h (low 64 bits; first differing bit %0d)",
               nm, cyc, act[63:0], expv[63:0], d);
    end
  endtask

  task automatic push_ev(input bit is_done, input logic [1033:0] d, input logic [8:0] h);
    ev_t e;
    e.cyc = cyc + 1; e.is_done = is_done; e.data = d; e.hdr = h;
    exp_q.push_back(e);
  endtask

  task automatic model_word(input logic [1:0] rid, input logic [4:0] idx,
                            input logic [1:0] ttl, input logic [54:0] pl);
    logic [1044:0] full;
    if (m_next < 0) begin
      if (idx == 0) begin m_words[0] = pl; m_rid = rid; m_ttl = ttl; m_next = 1; end
      else push_ev(0, m_last, '0);
    end else if (int'(idx) == m_next && rid == m_rid && ttl == m_ttl) begin
      m_words[m_next] = pl;
      m_next++;
      if (m_next == 19) begin
        for (int i = 0; i < 19; i++) full[i*55 +: 55] = m_words[i];
        m_last = full[1033:0];
        push_ev(1, m_last, {m_rid, 5'b0, m_ttl});
        m_next = -1;
      end
    end else begin
      push_ev(0, m_last, '0);
      if (idx == 0) begin m_words[0] = pl; m_rid = rid; m_ttl = ttl; m_next = 1; end
      else m_next = -1;
    end
  endtask

  task automatic send(input logic [1:0] rid, input logic [4:0] idx,
                      input logic [1:0] ttl, input logic [54:0] pl);
    @(negedge clk);
    chk("decap_busy", decap_busy, m_next >= 0);
    model_word(rid, idx, ttl, pl);
    data_recv = {pl, rid, idx, ttl};
    data_recv_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("decap_busy", decap_busy, m_next >= 0);
      data_recv = {$urandom, $urandom};
      data_recv_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [1:0] rid, input logic [1:0] ttl,
                            input logic [1033:0] d, input int gap, input int last);
    logic [1044:0] full;
    full = {11'($urandom), d};
    for (int i = 0; i <= last; i++) begin
      send(rid, 5'(i), ttl, full[i*55 +: 55]);
      if (i < last) idle(gap);
    end
  endtask

  task automatic check_zero_outputs();
    chk("rst_data", data_dfx_recv, '0);
    chk("rst_hdr", header_pkt_recv, '0);
    chk("rst_done", decap_done, 0);
    chk("rst_err", decap_err, 0);
    chk("rst_busy", decap_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_recv_valid = 1'b0;
    #1;
    check_zero_outputs();
    m_next = -1;
    m_last = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [1033:0] rand_data();
    logic [1055:0] b;
    for (int k = 0; k < 33; k++) b[k*32 +: 32] = $urandom;
    return b[1033:0];
  endfunction

  // Monitor: pop expected strobes as the DUT presents them.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (decap_done && decap_err) chk("done_err_exclusive", {decap_done, decap_err}, 2'b10);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk(e.is_done ? "missing_done" : "missing_err", cyc, e.cyc);
      end
      if (decap_done || decap_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {decap_done, decap_err}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_is_done", decap_done, e.is_done);
          chk("strobe_is_err", decap_err, !e.is_done);
          chk("data_dfx_recv", data_dfx_recv, e.data);
          if (e.is_done) chk("header_pkt_recv", header_pkt_recv, e.hdr);
        end
      end
    end
  end

  initial begin
    logic [1055:0] pb;
    logic [3:0]    nib;
    logic [1033:0] pat, dA, dB;
    logic [1:0]    rid, ttl, wr, wt;
    logic [4:0]    wi;
    logic [1044:0] full;
    int            r;

    repeat (3) @(negedge clk);
    check_zero_outputs();
    rst = 1'b0;

    for (int k = 0; k < 33; k++) begin
      nib = 4'((k % 8) + 1);
      pb[k*32 +: 32] = {8{nib}};
    end
    pat = pb[1033:0];

    // Clean frame, then the same frame gapped by 3 idle cycles per beat.
    send_frame(2'b10, 2'b01, pat, 0, 18);
    idle(2);
    send_frame(2'b10, 2'b01, ~pat, 3, 18);
    idle(2);

    // Skipped index 7.
    send_frame(2'b10, 2'b01, rand_data(), 0, 6);
    send(2'b10, 5'd8, 2'b01, 55'({$urandom, $urandom}));
    idle(2);

    // Resync: partial frame A, then frame B interrupts with its word 0.
    dA = rand_data(); dB = rand_data();
    send_frame(2'b10, 2'b01, dA, 0, 9);
    send_frame(2'b01, 2'b11, dB, 0, 18);
    // Back-to-back frame with no gap.
    send_frame(2'b00, 2'b10, rand_data(), 0, 18);
    idle(2);

    // Router mismatch at word 5, then a stray word in IDLE.
    send_frame(2'b10, 2'b01, rand_data(), 0, 4);
    send(2'b11, 5'd5, 2'b01, 55'({$urandom, $urandom}));
    idle(1);
    send(2'b10, 5'd3, 2'b01, 55'({$urandom, $urandom}));
    idle(2);

    // Reset mid-frame, then a clean frame.
    send_frame(2'b10, 2'b01, rand_data(), 0, 10);
    do_reset();
    send_frame(2'b10, 2'b01, pat, 0, 18);
    idle(2);

    // Randomized frames with occasional header corruption and random gaps.
    for (int f = 0; f < 40; f++) begin
      rid = 2'($urandom); ttl = 2'($urandom);
      full = {11'($urandom), rand_data()};
      for (int i = 0; i < 19; i++) begin
        wr = rid; wt = ttl; wi = 5'(i);
        r = $urandom_range(0, 39);
        if (r == 0) wi = 5'($urandom_range(0, 31));
        else if (r == 1) wr = rid ^ 2'b01;
        else if (r == 2) wt = ttl ^ 2'b10;
        send(wr, wi, wt, full[i*55 +: 55]);
        idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0);
      end
    end

    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
